// File: rtl/fetch_stage_pkg.sv
// fetch_stage_pkg: shared widths, FSM encoding, reset PC default,
// NOP constant and the output-register bundle for the fetch stage.
package fetch_stage_pkg;

  localparam int ADDR_BUS = 32;
  localparam int INST_BUS = 32;

  typedef logic [ADDR_BUS-1:0] addr_t;
  typedef logic [INST_BUS-1:0] inst_t;

  typedef enum logic [1:0] {
    FETCH_ISSUE = 2'd0,
    FETCH_WAIT  = 2'd1,
    FETCH_HOLD  = 2'd2
  } fetch_state_e;

  localparam addr_t FETCH_RESET_PC = 32'hBFC0_0000;
  localparam inst_t NOP = '0;

  typedef struct packed {
    addr_t addr;
    inst_t inst;
    logic  valid;
  } fetch_out_t;

  function automatic addr_t seq_pc(addr_t pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// fetch_stage_if: instruction-memory request/response bus.
// master = fetch side (req/addr out), slave = memory side.
interface fetch_stage_if;
  import fetch_stage_pkg::*;

  logic  rom_req;
  addr_t rom_addr;
  logic  rom_gnt;
  logic  rom_rvalid;
  inst_t rom_rdata;

  modport master (
    output rom_req,
    output rom_addr,
    input  rom_gnt,
    input  rom_rvalid,
    input  rom_rdata
  );

  modport slave (
    input  rom_req,
    input  rom_addr,
    output rom_gnt,
    output rom_rvalid,
    output rom_rdata
  );

endinterface

// File: rtl/fetch_hold_buf.sv
// fetch_hold_buf: single-entry {addr, inst} buffer.
// Ports: clk, rst (sync, active-low), load, clear, load_addr/inst, valid/addr/inst.
module fetch_hold_buf
  import fetch_stage_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  load,
  input  logic  clear,
  input  addr_t load_addr,
  input  inst_t load_inst,
  output logic  valid,
  output addr_t addr,
  output inst_t inst
);

  always_ff @(posedge clk) begin
    if (!rst || clear) begin
      valid <= 1'b0;
      addr  <= '0;
      inst  <= NOP;
    end else if (load) begin
      valid <= 1'b1;
      addr  <= load_addr;
      inst  <= load_inst;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC owner, one-outstanding imem fetch, stall buffer, delay-slot
// branches, flush redirect. Ports: clk, rst (sync low), stall, flush/flush_pc,
// branch_flag/addr, rom (fetch_stage_if.master), addr/inst/inst_valid.
// Optional FETCH_ALIGN_CHECK_EN adds fetch_adel (misaligned-PC exception).
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter addr_t RESET_PC = FETCH_RESET_PC
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  stall,
  input  logic  flush,
  input  addr_t flush_pc,
  input  logic  branch_flag,
  input  addr_t branch_addr,
  fetch_stage_if.master rom,
  output addr_t addr,
  output inst_t inst,
  output logic  inst_valid
`ifdef FETCH_ALIGN_CHECK_EN
  ,
  output logic  fetch_adel
`endif
);

  fetch_state_e state_q, state_d;
  addr_t pc_q, pc_d;
  logic  rpend_q, rpend_d;
  addr_t raddr_q, raddr_d;
  logic  disc_q, disc_d;
  fetch_out_t out_q, out_d;
  addr_t adv_pc;
  logic  deliver;

  logic  hb_load, hb_clear, hb_valid;
  addr_t hb_addr;
  inst_t hb_inst;

  fetch_hold_buf u_hold (
    .clk       (clk),
    .rst       (rst),
    .load      (hb_load),
    .clear     (hb_clear),
    .load_addr (pc_q),
    .load_inst (rom.rom_rdata),
    .valid     (hb_valid),
    .addr      (hb_addr),
    .inst      (hb_inst)
  );

`ifdef FETCH_ALIGN_CHECK_EN
  logic misalign;
  logic adel_q, adel_d;
  assign misalign     = (pc_q[1:0] != 2'b00);
  assign rom.rom_req  = (state_q == FETCH_ISSUE) && !misalign;
  assign rom.rom_addr = pc_q;
  assign fetch_adel   = adel_q;
`else
  assign rom.rom_req  = (state_q == FETCH_ISSUE);
  assign rom.rom_addr = {pc_q[ADDR_BUS-1:2], 2'b00};
`endif

  assign addr       = out_q.addr;
  assign inst       = out_q.inst;
  assign inst_valid = out_q.valid;

  // A branch seen in the same cycle its delay slot is delivered
  // must jump straight to the target.
  always_comb begin
    adv_pc = rpend_q ? raddr_q : seq_pc(pc_q);
    if (branch_flag) adv_pc = branch_addr;
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    rpend_d  = rpend_q;
    raddr_d  = raddr_q;
    disc_d   = disc_q;
    out_d    = out_q;
    hb_load  = 1'b0;
    hb_clear = 1'b0;
    deliver  = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
    adel_d   = adel_q;
`endif
    if (!stall) begin
      out_d.inst  = NOP;
      out_d.valid = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
      adel_d      = 1'b0;
`endif
      if (branch_flag) begin
        rpend_d = 1'b1;
        raddr_d = branch_addr;
      end
    end
    if (flush) begin
      pc_d        = flush_pc;
      out_d.inst  = NOP;
      out_d.valid = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
      adel_d      = 1'b0;
`endif
      hb_clear    = 1'b1;
      rpend_d     = 1'b0;
      disc_d      = 1'b0;
      state_d     = FETCH_ISSUE;
      // A response is still owed (in WAIT, or granted this very
      // cycle): wait it out and drop it before issuing again.
      if ((state_q == FETCH_WAIT && !rom.rom_rvalid) ||
          (rom.rom_req && rom.rom_gnt)) begin
        disc_d  = 1'b1;
        state_d = FETCH_WAIT;
      end
    end else begin
      unique case (state_q)
        FETCH_ISSUE: begin
`ifdef FETCH_ALIGN_CHECK_EN
          if (misalign) begin
            if (!stall) begin
              out_d  = '{addr: pc_q, inst: NOP, valid: 1'b1};
              adel_d = 1'b1;
            end
          end else if (rom.rom_gnt) begin
            state_d = FETCH_WAIT;
          end
`else
          if (rom.rom_gnt) state_d = FETCH_WAIT;
`endif
        end
        FETCH_WAIT: begin
          if (rom.rom_rvalid) begin
            if (disc_q) begin
              disc_d  = 1'b0;
              state_d = FETCH_ISSUE;
            end else if (!stall) begin
              out_d   = '{addr: pc_q, inst: rom.rom_rdata, valid: 1'b1};
              deliver = 1'b1;
              state_d = FETCH_ISSUE;
            end else begin
              hb_load = 1'b1;
              state_d = FETCH_HOLD;
            end
          end
        end
        FETCH_HOLD: begin
          if (!stall) begin
            out_d    = '{addr: hb_addr, inst: hb_inst, valid: hb_valid};
            hb_clear = 1'b1;
            deliver  = 1'b1;
            state_d  = FETCH_ISSUE;
          end
        end
        default: state_d = FETCH_ISSUE;
      endcase
      if (deliver) begin
        pc_d    = adv_pc;
        rpend_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= FETCH_ISSUE;
      pc_q    <= RESET_PC;
      rpend_q <= 1'b0;
      raddr_q <= '0;
      disc_q  <= 1'b0;
      out_q   <= '{addr: RESET_PC, inst: NOP, valid: 1'b0};
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      rpend_q <= rpend_d;
      raddr_q <= raddr_d;
      disc_q  <= disc_d;
      out_q   <= out_d;
    end
  end

`ifdef FETCH_ALIGN_CHECK_EN
  always_ff @(posedge clk) begin
    if (!rst) adel_q <= 1'b0;
    else      adel_q <= adel_d;
  end
`endif

endmodule
